// File: rtl/prio_arb_pkg.sv
// prio_arb_pkg: shared widths, FSM state type and one-hot helper for prio_arbiter.
package prio_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;
  localparam int CNT_W = 8;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [NUM_REQ-1:0] id2oh(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/prio_enc4v.sv
// prio_enc4v: 4:2 fixed-priority encoder, bit 3 highest, with valid flag.
module prio_enc4v
  import prio_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_vld
);
  assign o_idx = i_req[3] ? 2'd3 : i_req[2] ? 2'd2 : i_req[1] ? 2'd1 : 2'd0;
  assign o_vld = |i_req;
endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: 4-way priority arbiter with no preemption, hold timeout and revoke masking.
// Define PRIO_ARB_ROUND_ROBIN_EN to rotate priority after every grant end.
module prio_arbiter
  import prio_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_rev_id;
  logic               r_rev_vld;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_enc_in;
  logic [ID_W-1:0]    w_enc_idx;
  logic [ID_W-1:0]    w_win;
  logic               w_enc_vld;
  logic               w_end;
  // A revoked requester sits out one arbitration only when someone else is waiting.
  assign w_masked = req & ~id2oh(r_rev_id);
  assign w_elig   = (r_rev_vld && |w_masked) ? w_masked : req;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;
  assign w_enc_in = NUM_REQ'({w_elig, w_elig} >> r_ptr);
  assign w_win    = w_enc_idx + r_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (w_end) r_ptr <= r_id;
`else
  assign w_enc_in = w_elig;
  assign w_win    = w_enc_idx;
`endif
  prio_enc4v u_enc (
    .i_req (w_enc_in),
    .o_idx (w_enc_idx),
    .o_vld (w_enc_vld)
  );
  // Timeout follows the live req so a release in the same cycle suppresses it.
  assign timeout   = (r_state == GRANT) && req[r_id] && (r_cnt >= HOLD_LAST);
  assign w_end     = (r_state == GRANT) && (!req[r_id] || r_cnt >= HOLD_LAST);
  assign gnt       = r_gnt;
  assign gnt_id    = r_id;
  assign gnt_valid = (r_state == GRANT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_rev_vld <= 1'b0;
      r_rev_id  <= '0;
    end else if (r_state == IDLE) begin
      if (w_enc_vld) begin
        r_state   <= GRANT;
        r_gnt     <= id2oh(w_win);
        r_id      <= w_win;
        r_cnt     <= '0;
        r_rev_vld <= 1'b0;
      end
    end else if (w_end) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      if (timeout) begin
        r_rev_vld <= 1'b1;
        r_rev_id  <= r_id;
      end
    end else
      r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
endmodule
